// File: rtl/mult_cell_combine.sv
// Final merge stage of the multiplier cell: folds three 16x16 partial products into the
// low 32 product bits over a 2-stage valid/ready pipeline. Define MULT_CELL_COMBINE_PARITY_EN for out_parity.
module mult_cell_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef MULT_CELL_COMBINE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             r_a_valid;
  logic [31:0]      r_a_lo;
  logic [15:0]      r_a_mid;
  logic [TAG_W-1:0] r_a_tag;
  logic             r_out_valid;
  logic [31:0]      r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_b_ready;
  logic             w_accept;
  logic             w_a_to_b;
  logic [15:0]      w_a_mid;
  logic [31:0]      w_b_result;
  logic             w_unused_hi;

  assign w_b_ready = ~r_out_valid | out_ready;
  assign in_ready  = ~r_a_valid | w_b_ready;

  // Flush suppresses both moves even though in_ready may still read 1.
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_a_to_b  = r_a_valid & w_b_ready & ~flush;

  // The carry out of the middle sum and the upper product halves only reach bits >= 32.
  assign w_a_mid     = in_p2[15:0] + in_p3[15:0];
  assign w_b_result  = r_a_lo + {r_a_mid, 16'h0000};
  assign w_unused_hi = ^{in_p2[31:16], in_p3[31:16]};

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_a_valid   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept)      r_a_valid <= 1'b1;
      else if (w_a_to_b) r_a_valid <= 1'b0;

      if (w_a_to_b)       r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
    end
  end

  // NOTE: data registers are reset too, so a reset leaves out_result/out_tag at zero;
  // flush deliberately leaves them stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_lo       <= '0;
      r_a_mid      <= '0;
      r_a_tag      <= '0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else begin
      if (w_accept) begin
        r_a_lo  <= in_p1;
        r_a_mid <= w_a_mid;
        r_a_tag <= in_tag;
      end
      if (w_a_to_b) begin
        r_out_result <= w_b_result;
        r_out_tag    <= r_a_tag;
      end
    end
  end

`ifdef MULT_CELL_COMBINE_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk) begin
    if (reset)         r_out_parity <= 1'b0;
    else if (w_a_to_b) r_out_parity <= ^w_b_result;
  end

  assign out_parity = r_out_parity;
`endif

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

  // A stalled result must not move until the consumer takes it.
  a_stall_stable: assert property (@(posedge clk)
    (r_out_valid && !out_ready && !reset) |=> ($stable(out_result) && $stable(out_tag)));

endmodule

// File: tb/tb_mult_cell_combine.sv
// Self-checking bench for mult_cell_combine: directed vector table, hand-built handshake
// corner sequences, and a randomized run scored against a transaction-level queue model.
module tb_mult_cell_combine;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_p1, in_p2, in_p3, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef MULT_CELL_COMBINE_PARITY_EN
  logic             out_parity;
`endif

  mult_cell_combine #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
`ifdef MULT_CELL_COMBINE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the low 32 bits of src1*src2 written as a sum of shifted partial products.
  function automatic logic [31:0] model_pp(input logic [31:0] p1, p2, p3);
    logic [63:0] s;
    s = 64'(p1) + (64'(p2) << 16) + (64'(p3) << 16);
    return s[31:0];
  endfunction

  function automatic logic parity_of(input logic [31:0] v);
    int ones = 0;
    for (int i = 0; i < 32; i++) if (v[i]) ones++;
    return ones[0];
  endfunction

  typedef struct {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        expq[$];
  int          out_tags[$];
  int          out_cycs[$];
  logic [31:0] cur_exp;

  // Monitor: scoreboards every output handshake and checks stall stability.
  logic             prev_stall = 1'b0;
  logic [31:0]      prev_result;
  logic [TAG_W-1:0] prev_tag;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_result_stable", out_result, prev_result);
      check("stall_tag_stable", 32'(out_tag), 32'(prev_tag));
    end
    prev_stall  = out_valid & ~out_ready & ~reset & ~flush;
    prev_result = out_result;
    prev_tag    = out_tag;

    if (!reset && out_valid && out_ready) begin
      out_tags.push_back(int'(out_tag));
      out_cycs.push_back(cyc);
      if (expq.size() == 0) begin
        check("sb_unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("sb_result", out_result, e.result);
        check("sb_tag", 32'(out_tag), 32'(e.tag));
`ifdef MULT_CELL_COMBINE_PARITY_EN
        check("sb_parity", 32'(out_parity), 32'(parity_of(e.result)));
`endif
      end
    end
    if (reset || flush) expq.delete();
    else if (in_valid && in_ready) expq.push_back('{result: cur_exp, tag: in_tag});
  end

  task automatic drive(input logic [31:0] p1, p2, p3, input int tag, input logic [31:0] exp);
    in_valid = 1'b1;
    in_p1    = p1;
    in_p2    = p2;
    in_p3    = p3;
    in_tag   = TAG_W'(tag);
    cur_exp  = exp;
  endtask

  task automatic drive_tag(input int tag);
    drive(32'h0001_0000 + 32'(tag), 32'(tag) * 32'h11, 32'h3, tag,
          model_pp(32'h0001_0000 + 32'(tag), 32'(tag) * 32'h11, 32'h3));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fill both stages with out_ready low: two entries tagged t0 and t0+1.
  task automatic fill_both(input int t0);
    out_ready = 1'b0;
    drive_tag(t0);
    tick();
    drive_tag(t0 + 1);
    tick();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] p1, p2, p3;
    int          tag;
    logic [31:0] exp_result;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [31:0] s1, s2;
    logic [63:0] prod;
    int          acc;

    #60_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] s1, s2;
    logic [63:0] prod;
    int          acc;
    logic        accepted;

    vecs[0] = '{32'h0000_000A, 32'h0000_0023, 32'h0000_0006, 3,  32'h0029_000A};
    vecs[1] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'hFFFE_0001, 7,  32'h0000_0001};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'hABCD_0001, 32'h0000_0002, 31, 32'h1237_5678};
    vecs[4] = '{32'h0000_0000, 32'h0000_FFFF, 32'h0000_0001, 1,  32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 16, 32'h0000_FFFF};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_p1 = '0; in_p2 = '0; in_p3 = '0; in_tag = '0; cur_exp = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;

    // Directed vectors: one at a time, result visible two cycles after presentation.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].tag, vecs[i].exp_result);
      @(negedge clk);
      check("vec_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("vec_not_early", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_result", out_result, vecs[i].exp_result);
      check("vec_tag", 32'(out_tag), 32'(vecs[i].tag));
`ifdef MULT_CELL_COMBINE_PARITY_EN
      check("vec_parity", 32'(out_parity), 32'(parity_of(vecs[i].exp_result)));
`endif
      tick();
    end
    tick();

    // Back-to-back: four inputs, four results on consecutive cycles.
    out_tags.delete(); out_cycs.delete();
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive_tag(c);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 4) check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    check("b2b_count", 32'(out_tags.size()), 32'd4);
    for (int k = 0; k < out_tags.size() && k < 4; k++) begin
      check("b2b_order", 32'(out_tags[k]), 32'(k));
      if (k > 0) check("b2b_consecutive", 32'(out_cycs[k] - out_cycs[k-1]), 32'd1);
    end

    // Backpressure: consumer stalled, three inputs offered, only two fit.
    out_tags.delete();
    out_ready = 1'b0;
    acc = 0;
    drive_tag(10);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      accepted = in_valid & in_ready;
      tick();
      if (accepted) begin
        acc++;
        if (acc < 3) drive_tag(10 + acc);
        else in_valid = 1'b0;
      end
    end
    check("bp_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_held_tag", 32'(out_tag), 32'd10);
    check("bp_held_result", out_result, model_pp(32'h0001_000A, 32'd10 * 32'h11, 32'h3));
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      accepted = in_valid & in_ready;
      tick();
      if (accepted) in_valid = 1'b0;
    end
    check("bp_release_count", 32'(out_tags.size()), 32'd3);
    for (int k = 0; k < out_tags.size() && k < 3; k++)
      check("bp_release_order", 32'(out_tags[k]), 32'(10 + k));

    // Flush with both stages full and a new input offered in the same cycle.
    fill_both(20);
    @(negedge clk);
    check("fl_setup_full", 32'(out_valid), 32'd1);
    tick();
    out_tags.delete();
    out_ready = 1'b1;
    flush = 1'b1;
    drive_tag(22);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("fl_pipe_empty", 32'(out_valid), 32'd0);
      tick();
    end
    check("fl_nothing_emitted_after", 32'(out_tags.size()), 32'd1);
    drive_tag(23);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_new_not_early", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("fl_new_out_valid", 32'(out_valid), 32'd1);
    check("fl_new_tag", 32'(out_tag), 32'd23);
    tick(); tick();

    // Reset during a stall discards both entries.
    fill_both(24);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_out_result", out_result, 32'd0);
    check("rs_out_tag", 32'(out_tag), 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd1);
`ifdef MULT_CELL_COMBINE_PARITY_EN
    check("rs_out_parity", 32'(out_parity), 32'd0);
`endif
    tick();
    out_ready = 1'b1;
    tick(); tick();
    check("rs_no_ghost", 32'(out_valid), 32'd0);

    // Randomized traffic from real operands, with random backpressure and rare flushes.
    accepted = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (!in_valid || accepted) begin
        if ($urandom_range(3) != 0) begin
          s1   = $urandom();
          s2   = $urandom();
          prod = 64'(s1) * 64'(s2);
          drive(32'(s1[15:0]) * 32'(s2[15:0]), 32'(s1[15:0]) * 32'(s2[31:16]),
                32'(s1[31:16]) * 32'(s2[15:0]), int'($urandom_range(31)), prod[31:0]);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(63) == 0);
      @(negedge clk);
      accepted = in_valid & in_ready & ~flush;
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("rand_drained", 32'(expq.size()), 32'd0);
    check("rand_idle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
